qpsk_byte_packer: RTL and testbench
===================================

Name: qpsk_byte_packer

Overview:
- Downstream of the QPSK hard-decision demodulator.
- Takes the 2-bit decided symbol (dibit) stream for data subcarriers and packs four dibits into one byte, MSB-first.
- Buffers bytes in a small FIFO and presents them on a valid/ready byte interface to the MAC/byte sink.
- Marks the last byte of each 1282-byte frame (5128 dibits) and flags FIFO overflow.

Parameters:
- FIFO_DEPTH, 16, byte FIFO entries; power of two, minimum 4.
- FRAME_BYTES, 1282, bytes per frame; m_last asserts on byte FRAME_BYTES-1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sop  input  1  start of OFDM symbol, one-cycle pulse from the demod domain.
- in_data  input  2  decided dibit; bit1 = I decision, bit0 = Q decision.
- in_valid  input  1  in_data holds a data-subcarrier dibit this cycle.
- m_data  output  8  byte at FIFO head.
- m_valid  output  1  m_data valid.
- m_ready  input  1  sink accepts the byte when m_valid && m_ready.
- m_last  output  1  head byte is last byte of frame; qualified by m_valid.
- overflow  output  1  sticky; a completed byte was dropped because the FIFO was full.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset, asynchronous and active-high, clears all state:
  - m_valid=0, m_data=0, m_last=0, overflow=0, level=0.
  - Dibit phase=0, partial-byte register=0, frame byte counter=0, FIFO pointers=0.
  - Reset asserted mid-frame discards partial and buffered bytes; the first dibit after release starts byte 0 of a new frame.
- Packing:
  - A 2-bit phase counter advances on each in_valid.
  - Phase 0 -> bits[7:6], phase 1 -> [5:4], phase 2 -> [3:2], phase 3 -> [1:0].
  - On the phase-3 edge, the assembled byte {p[7:2], in_data} is written to the FIFO in that same edge, and the phase returns to 0.
- sop handling:
  - sop forces phase to 0; any partial byte (phase 1..3) is discarded silently.
  - The frame byte counter is not affected by sop.
  - If sop and in_valid occur together, that dibit is phase 0 of a new byte: it is written to bits[7:6] and the phase becomes 1.
- Frame counter:
  - Increments on every completed byte, whether written or dropped, so frame alignment survives overflow.
  - Wraps from FRAME_BYTES-1 to 0.
  - The last flag is stored per FIFO entry (9-bit entries: {last, byte}).
- FIFO:
  - First-word fall-through; m_valid = (level != 0).
  - m_data/m_last come from the head entry, registered storage.
  - Latency: byte visible on m_data the cycle after its fourth dibit is sampled, when the FIFO was empty.
  - Pop on m_valid && m_ready.
  - A write is accepted when level < FIFO_DEPTH, or when full and a pop occurs in the same cycle (level unchanged).
  - Simultaneous push and pop at any level leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; level saturates at FIFO_DEPTH and never underflows.
- Overflow:
  - A completed byte arriving with level==FIFO_DEPTH and no pop is dropped.
  - overflow is set the next cycle and stays set until rst.
- m_ready while m_valid=0 has no effect.
- m_data and m_last hold stable while m_valid && !m_ready.
- in_valid with rst high is ignored.

Test Plan:
- Reset, then dibits 2'b11,2'b00,2'b10,2'b01 on consecutive cycles, m_ready=1 -> m_data=8'hC9, m_valid high exactly one cycle, starting one cycle after the 4th dibit; level returns to 0.
- Dibits 01,10, then sop with in_valid and dibit 11, then 00,00,01 -> first partial dropped; only byte 8'hC1 emitted; no overflow.
- m_ready=0, 20 bytes streamed (FIFO_DEPTH=16) -> level=16; bytes 17..20 dropped; overflow=1 from the cycle after byte 17 completes. Then m_ready=1 -> exactly 16 bytes emitted in order, matching the first 16 input bytes.
- FIFO full with m_ready=1 and a byte completing in the same cycle -> byte accepted, level stays 16, overflow stays 0.
- Stream 5128 dibits as random data, then 4 more, with m_ready=1 -> m_last high only on byte 1281; byte 1282 has m_last=0; byte counter wrapped.
- Assert rst with level=5 and phase=2 -> outputs zero immediately (asynchronously); after release, next four dibits 00,00,00,11 yield 8'h03 as frame byte 0.

Source files
------------

// File: rtl/qpsk_byte_packer_if.sv
// Byte-packer interface: dibit input side plus valid/ready byte output side.
// The packer drives the byte stream, so it takes the master modport; the
// demodulator/sink environment takes the slave modport.
interface qpsk_byte_packer_if #(
    parameter int FIFO_DEPTH = 16
) ();
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          sop;
    logic [1:0]    in_data;
    logic          in_valid;
    logic [7:0]    m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          overflow;
    logic [LW-1:0] level;

    modport master (
        input  sop, in_data, in_valid, m_ready,
        output m_data, m_valid, m_last, overflow, level
    );

    modport slave (
        output sop, in_data, in_valid, m_ready,
        input  m_data, m_valid, m_last, overflow, level
    );
endinterface

// File: rtl/qpsk_byte_packer.sv
// QPSK byte packer: gathers four hard-decision dibits MSB-first into a byte,
// tags the last byte of each frame, and buffers bytes in a first-word
// fall-through FIFO presented on a valid/ready interface. A completed byte
// that finds the FIFO full (with no pop in the same cycle) is dropped and
// sets a sticky overflow flag; the frame counter still advances so frame
// alignment is preserved.
module qpsk_byte_packer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_BYTES = 1282
) (
    input  logic                clk,
    input  logic                rst,
    qpsk_byte_packer_if.master  bus
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int FCW = $clog2(FRAME_BYTES);

    localparam logic [LW-1:0]  DEPTH_L  = LW'(FIFO_DEPTH);
    localparam logic [FCW-1:0] LAST_CNT = FCW'(FRAME_BYTES - 1);

    // Packing state: phase counts dibits in the current byte, part_r keeps
    // byte bits [7:2]; bits [1:0] come straight from the fourth dibit.
    logic [1:0]     phase_r;
    logic [5:0]     part_r;

    // Frame position of the next completed byte.
    logic [FCW-1:0] frame_cnt_r;

    // FIFO storage, entries are {last, byte}.
    logic [8:0]     mem_r [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [LW-1:0]  level_r;
    logic           m_valid_r;
    logic           overflow_r;

    logic           byte_done_s;
    logic           full_s;
    logic           pop_s;
    logic           push_s;
    logic           drop_s;
    logic           last_s;
    logic [LW-1:0]  level_nxt_s;

    // A sop on the same cycle restarts the byte, so that dibit never completes one.
    assign byte_done_s = bus.in_valid && !bus.sop && (phase_r == 2'd3);
    assign full_s      = (level_r == DEPTH_L);
    assign pop_s       = m_valid_r && bus.m_ready;
    assign push_s      = byte_done_s && (!full_s || pop_s);
    assign drop_s      = byte_done_s && full_s && !pop_s;
    assign last_s      = (frame_cnt_r == LAST_CNT);

    // Next FIFO occupancy from the push/pop pair; push+pop leaves it unchanged.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + 1'b1;
            2'b01:   level_nxt_s = level_r - 1'b1;
            default: level_nxt_s = level_r;
        endcase
    end

    // Dibit packing: place each dibit by phase; sop restarts the byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r <= 2'd0;
            part_r  <= 6'h00;
        end else if (bus.sop) begin
            if (bus.in_valid) begin
                phase_r <= 2'd1;
                part_r  <= {bus.in_data, 4'h0};
            end else begin
                phase_r <= 2'd0;
                part_r  <= 6'h00;
            end
        end else if (bus.in_valid) begin
            case (phase_r)
                2'd0:    part_r[5:4] <= bus.in_data;
                2'd1:    part_r[3:2] <= bus.in_data;
                2'd2:    part_r[1:0] <= bus.in_data;
                default: part_r      <= part_r;
            endcase
            phase_r <= phase_r + 2'd1;
        end else begin
            phase_r <= phase_r;
            part_r  <= part_r;
        end
    end

    // Frame byte counter: counts every completed byte, written or dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= {FCW{1'b0}};
        end else if (byte_done_s) begin
            if (last_s) begin
                frame_cnt_r <= {FCW{1'b0}};
            end else begin
                frame_cnt_r <= frame_cnt_r + 1'b1;
            end
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // FIFO storage and pointers; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 9'h000;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {last_s, part_r, bus.in_data};
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Occupancy, output-valid and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_r    <= {LW{1'b0}};
            m_valid_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            level_r    <= level_nxt_s;
            m_valid_r  <= (level_nxt_s != {LW{1'b0}});
            overflow_r <= overflow_r | drop_s;
        end
    end

    // Head entry is read from registered storage; zero while the FIFO is empty.
    assign bus.m_data   = m_valid_r ? mem_r[rd_ptr_r][7:0] : 8'h00;
    assign bus.m_last   = m_valid_r ? mem_r[rd_ptr_r][8]   : 1'b0;
    assign bus.m_valid  = m_valid_r;
    assign bus.overflow = overflow_r;
    assign bus.level    = level_r;

endmodule

// File: tb/tb_qpsk_byte_packer.sv
// Self-checking bench for qpsk_byte_packer: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_qpsk_byte_packer;
    localparam int DEPTH  = 16;
    localparam int FRAMEB = 1282;

    logic clk = 1'b0;
    logic rst = 1'b0;

    qpsk_byte_packer_if #(.FIFO_DEPTH(DEPTH)) bus ();

    qpsk_byte_packer #(.FIFO_DEPTH(DEPTH), .FRAME_BYTES(FRAMEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: dibits collected for the current byte, FIFO contents
    // as {last, byte}, frame position of the next completed byte, overflow.
    logic [1:0] dq[$];
    logic [8:0] mq[$];
    int         mframe;
    bit         movf;

    typedef struct {
        bit         sop;
        bit         vld;
        logic [1:0] d;
        bit         rdy;
        bit         e_valid;
        logic [7:0] e_data;
        bit         e_last;
        int         e_level;
        bit         e_ovf;
    } vec_t;

    vec_t       tbl[13];
    logic [7:0] sent[20];
    int         idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        dq.delete();
        mq.delete();
        mframe = 0;
        movf   = 1'b0;
    endfunction

    function automatic void model_step(input bit s, input bit v, input logic [1:0] d, input bit r);
        bit         pop;
        bit         full;
        bit         done;
        logic [7:0] b;
        pop  = (mq.size() > 0) && r;
        full = (mq.size() == DEPTH);
        done = 1'b0;
        b    = 8'h00;
        if (s) dq.delete();
        if (v) begin
            dq.push_back(d);
            if (dq.size() == 4) begin
                b = {dq[0], dq[1], dq[2], dq[3]};
                dq.delete();
                done = 1'b1;
            end
        end
        if (pop) void'(mq.pop_front());
        if (done) begin
            if (!full || pop) mq.push_back({(mframe == FRAMEB - 1), b});
            else              movf = 1'b1;
            mframe = (mframe + 1) % FRAMEB;
        end
    endfunction

    task automatic check_model();
        chk("m_valid", bus.m_valid, mq.size() != 0);
        chk("level", 32'(bus.level), mq.size());
        chk("overflow", bus.overflow, movf);
        if (mq.size() > 0) begin
            chk("m_data", bus.m_data, mq[0][7:0]);
            chk("m_last", bus.m_last, mq[0][8]);
        end
    endtask

    task automatic drive_cycle(input bit s, input bit v, input logic [1:0] d, input bit r);
        bus.sop      = s;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.m_ready  = r;
        model_step(s, v, d, r);
        @(posedge clk);
        #1;
    endtask

    // Assert reset away from a clock edge, check outputs clear immediately,
    // hold across one edge with in_valid high (must be ignored), release.
    task automatic apply_reset();
        rst          = 1'b1;
        bus.sop      = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 2'b11;
        bus.m_ready  = 1'b1;
        model_reset();
        #1;
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_overflow", bus.overflow, 0);
        chk("rst_level", 32'(bus.level), 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 2'b00;
        bus.m_ready  = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit r);
        for (int j = 0; j < 4; j++) begin
            drive_cycle(1'b0, 1'b1, b[7 - 2*j -: 2], r);
        end
    endtask

    initial begin
        bus.sop = 1'b0; bus.in_valid = 1'b0; bus.in_data = 2'b00; bus.m_ready = 1'b0;

        // Directed vectors: C9 with one-cycle visibility, then sop drops a partial -> C1.
        tbl[0]  = '{1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 8'hC9, 1'b0, 1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 8'hC1, 1'b0, 1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0};

        @(posedge clk);
        #1;
        apply_reset();

        for (int i = 0; i < 13; i++) begin
            drive_cycle(tbl[i].sop, tbl[i].vld, tbl[i].d, tbl[i].rdy);
            chk("tbl_m_valid", bus.m_valid, tbl[i].e_valid);
            chk("tbl_level", 32'(bus.level), tbl[i].e_level);
            chk("tbl_overflow", bus.overflow, tbl[i].e_ovf);
            if (tbl[i].e_valid) begin
                chk("tbl_m_data", bus.m_data, tbl[i].e_data);
                chk("tbl_m_last", bus.m_last, tbl[i].e_last);
            end
        end

        // Overflow: 20 bytes into a 16-deep FIFO with the sink stalled, then drain.
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            sent[k] = 8'($urandom);
            send_byte(sent[k], 1'b0);
            check_model();
            chk("ovf_level", 32'(bus.level), (k < DEPTH) ? k + 1 : DEPTH);
            chk("ovf_flag", bus.overflow, k >= DEPTH);
        end
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_valid", bus.m_valid, 1);
            chk("drain_data", bus.m_data, sent[i]);
            drive_cycle(1'b0, 1'b0, 2'b00, 1'b1);
            check_model();
        end
        chk("drain_empty", bus.m_valid, 0);
        chk("drain_ovf_sticky", bus.overflow, 1);

        // Full FIFO, byte completes on the same edge as a pop: accepted, no overflow.
        apply_reset();
        for (int k = 0; k < DEPTH; k++) begin
            sent[k] = 8'($urandom);
            send_byte(sent[k], 1'b0);
        end
        chk("full_level", 32'(bus.level), DEPTH);
        sent[DEPTH] = 8'($urandom);
        for (int j = 0; j < 3; j++) drive_cycle(1'b0, 1'b1, sent[DEPTH][7 - 2*j -: 2], 1'b0);
        drive_cycle(1'b0, 1'b1, sent[DEPTH][1:0], 1'b1);
        check_model();
        chk("full_pp_level", 32'(bus.level), DEPTH);
        chk("full_pp_ovf", bus.overflow, 0);
        chk("full_pp_head", bus.m_data, sent[1]);
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive_cycle(1'b0, 1'b0, 2'b00, 1'b1);
            check_model();
        end

        // Frame boundary: 5128 + 4 random dibits with the sink always ready.
        apply_reset();
        idx = 0;
        for (int i = 0; i < 4 * (FRAMEB + 1); i++) begin
            drive_cycle(1'b0, 1'b1, 2'($urandom), 1'b1);
            check_model();
            if (bus.m_valid) begin
                chk("frame_last", bus.m_last, idx == FRAMEB - 1);
                idx++;
            end
        end
        chk("frame_bytes", idx, FRAMEB + 1);

        // Reset with level 5 and phase 2, then a fresh frame byte 0 = 03.
        apply_reset();
        for (int k = 0; k < 5; k++) send_byte(8'($urandom), 1'b0);
        drive_cycle(1'b0, 1'b1, 2'b10, 1'b0);
        drive_cycle(1'b0, 1'b1, 2'b01, 1'b0);
        chk("pre_rst_level", 32'(bus.level), 5);
        apply_reset();
        drive_cycle(1'b0, 1'b1, 2'b00, 1'b1);
        drive_cycle(1'b0, 1'b1, 2'b00, 1'b1);
        drive_cycle(1'b0, 1'b1, 2'b00, 1'b1);
        drive_cycle(1'b0, 1'b1, 2'b11, 1'b1);
        chk("post_rst_valid", bus.m_valid, 1);
        chk("post_rst_data", bus.m_data, 8'h03);
        chk("post_rst_last", bus.m_last, 0);
        check_model();

        // Random traffic with sop, gaps and stall windows against the model.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            drive_cycle($urandom_range(0, 15) == 0,
                        $urandom_range(0, 3) != 0,
                        2'($urandom),
                        ((i % 500) < 180) ? 1'b0 : 1'($urandom));
            check_model();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
